// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - IF stage: PC, instruction-memory handshake, one-entry hold buffer, IF/ID register
module fetch_stage #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      OP_HLT   = 4'hF,
  parameter logic [3:0]      OP_LLB   = 4'hA,
  parameter logic [3:0]      OP_LHB   = 4'hB
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_write_en,
  input  logic               if_id_write_en,
  input  logic               if_id_clean,
  input  logic [PC_W-1:0]    jump_target,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc_plus1,
  output logic               if_id_valid,
  output logic [3:0]         if_id_Rs,
  output logic [3:0]         if_id_Rt,
  output logic               run
);

  typedef enum logic [1:0] {S_FETCH, S_HOLD, S_HALT} state_t;

  state_t             r_state, w_state_nx;
  logic [PC_W-1:0]    r_pc, w_pc_nx;
  logic               r_squash, w_squash_nx;
  logic [INSTR_W-1:0] r_buf, w_buf_nx;
  logic [INSTR_W-1:0] r_if_instr, w_if_instr_nx;
  logic [PC_W-1:0]    r_if_pc1, w_if_pc1_nx;
  logic               r_if_valid, w_if_valid_nx;

  logic               w_avail;
  logic               w_adv;
  logic [INSTR_W-1:0] w_data;
  logic [PC_W-1:0]    w_pc_inc;

  assign w_avail  = ((r_state == S_FETCH) && imem_valid && !r_squash) || (r_state == S_HOLD);
  assign w_data   = (r_state == S_HOLD) ? r_buf : imem_rdata;
  assign w_adv    = pc_write_en && if_id_write_en;
  assign w_pc_inc = r_pc + PC_W'(1);

  always_comb begin
    w_state_nx    = r_state;
    w_pc_nx       = r_pc;
    w_squash_nx   = r_squash;
    w_buf_nx      = r_buf;
    w_if_instr_nx = r_if_instr;
    w_if_pc1_nx   = r_if_pc1;
    w_if_valid_nx = r_if_valid;

    if (if_id_clean) begin
      w_if_instr_nx = '0;
      w_if_pc1_nx   = '0;
      w_if_valid_nx = 1'b0;
      w_pc_nx       = jump_target;
      w_state_nx    = S_FETCH;
      // An outstanding request still owes one response for the old address.
      w_squash_nx   = (r_state == S_FETCH) && !imem_valid;
    end else if (w_avail) begin
      if (w_adv) begin
        w_if_instr_nx = w_data;
        w_if_pc1_nx   = w_pc_inc;
        w_if_valid_nx = 1'b1;
        w_pc_nx       = w_pc_inc;
        w_state_nx    = (w_data[INSTR_W-1 -: 4] == OP_HLT) ? S_HALT : S_FETCH;
      end else begin
        if (r_state == S_FETCH) w_buf_nx = imem_rdata;
        w_state_nx = S_HOLD;
      end
    end else begin
      if (r_state == S_FETCH && imem_valid) w_squash_nx = 1'b0;
      if (if_id_write_en) begin
        w_if_instr_nx = '0;
        w_if_pc1_nx   = '0;
        w_if_valid_nx = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_FETCH;
      r_pc       <= RESET_PC;
      r_squash   <= 1'b0;
      r_buf      <= '0;
      r_if_instr <= '0;
      r_if_pc1   <= '0;
      r_if_valid <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_pc       <= w_pc_nx;
      r_squash   <= w_squash_nx;
      r_buf      <= w_buf_nx;
      r_if_instr <= w_if_instr_nx;
      r_if_pc1   <= w_if_pc1_nx;
      r_if_valid <= w_if_valid_nx;
    end
  end

  assign imem_req       = (r_state == S_FETCH);
  assign imem_addr      = r_pc;
  assign run            = (r_state != S_HALT);
  assign if_id_instr    = r_if_instr;
  assign if_id_pc_plus1 = r_if_pc1;
  assign if_id_valid    = r_if_valid;
  assign if_id_Rt       = r_if_instr[3:0];
  // Load-byte ops carry their source register in the rd slot.
  assign if_id_Rs       = (r_if_instr[INSTR_W-1 -: 4] == OP_LLB || r_if_instr[INSTR_W-1 -: 4] == OP_LHB)
                          ? r_if_instr[11:8] : r_if_instr[7:4];

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed stimulus with scoreboard checking of fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst, pc_write_en, if_id_write_en, if_id_clean;
  logic [15:0] jump_target;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus1;
  logic        if_id_valid;
  logic [3:0]  if_id_Rs, if_id_Rt;
  logic        run;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc1;
    logic [3:0]  rs;
    logic [3:0]  rt;
  } exp_t;
  exp_t exp_q[$];

  logic [15:0] mem [0:255];
  int          lat;
  logic        m_busy;
  int          m_cnt;
  logic [15:0] m_addr;
  logic        mon_we;

  fetch_stage dut (
    .clk(clk), .rst(rst), .pc_write_en(pc_write_en), .if_id_write_en(if_id_write_en),
    .if_id_clean(if_id_clean), .jump_target(jump_target), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .if_id_instr(if_id_instr), .if_id_pc_plus1(if_id_pc_plus1), .if_id_valid(if_id_valid),
    .if_id_Rs(if_id_Rs), .if_id_Rt(if_id_Rt), .run(run)
  );

  always #5 clk = ~clk;

  // Memory model: a request answers in its lat-th cycle (lat=1 is zero-wait), address latched at start.
  always_comb begin
    if (m_busy) begin
      imem_valid = (m_cnt == lat - 1);
      imem_rdata = mem[m_addr[7:0]];
    end else begin
      imem_valid = imem_req && (lat == 1);
      imem_rdata = mem[imem_addr[7:0]];
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
    end else if (m_busy) begin
      if (imem_valid) m_busy <= 1'b0;
      else            m_cnt  <= m_cnt + 1;
    end else if (imem_req && !imem_valid) begin
      m_busy <= 1'b1;
      m_cnt  <= 1;
      m_addr <= imem_addr;
    end
  end

  // IF/ID shows a newly loaded instruction only if it was writable at the previous edge.
  always @(posedge clk) mon_we <= if_id_write_en && !rst;

  always @(negedge clk) begin
    if (mon_we === 1'b1 && if_id_valid === 1'b1) begin
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected instr=%h pc1=%h", if_id_instr, if_id_pc_plus1);
      end else begin
        e = exp_q.pop_front();
        if ({if_id_instr, if_id_pc_plus1, if_id_Rs, if_id_Rt} !== e) begin
          failures++;
          $display("FAIL sb_ifid actual instr=%h pc1=%h rs=%h rt=%h expected instr=%h pc1=%h rs=%h rt=%h",
                   if_id_instr, if_id_pc_plus1, if_id_Rs, if_id_Rt, e.instr, e.pc1, e.rs, e.rt);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] instr, input logic [15:0] pc1,
                      input logic [3:0] rs, input logic [3:0] rt);
    exp_q.push_back('{instr, pc1, rs, rt});
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_valid"}, 32'(if_id_valid), 32'd0);
    chk({tag, "_instr"}, 32'(if_id_instr), 32'd0);
    chk({tag, "_pc1"},   32'(if_id_pc_plus1), 32'd0);
    chk({tag, "_rsrt"},  32'({if_id_Rs, if_id_Rt}), 32'd0);
    chk({tag, "_addr"},  32'(imem_addr), 32'd0);
    chk({tag, "_req"},   32'(imem_req), 32'd1);
    chk({tag, "_run"},   32'(run), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    mem[0] = 16'h1123; mem[1] = 16'h2456; mem[2] = 16'h3789; mem[3] = 16'h4321;
    mem[4] = 16'h5678; mem[5] = 16'h9999; mem[8'h40] = 16'h1234; mem[8'h41] = 16'hF000;
    mem[8'h10] = 16'h2AB3; mem[8'h11] = 16'hA5C0; mem[8'h12] = 16'h7777;

    rst = 1'b1; pc_write_en = 1'b1; if_id_write_en = 1'b1; if_id_clean = 1'b0;
    jump_target = 16'h0; lat = 1;
    cyc(); cyc();
    // Zero-wait streaming
    chk_reset("rst1");
    push(16'h1123, 16'h1, 4'h2, 4'h3);
    push(16'h2456, 16'h2, 4'h5, 4'h6);
    push(16'h3789, 16'h3, 4'h8, 4'h9);
    rst = 1'b0;
    cyc(); chk("t1_addr1", 32'(imem_addr), 32'h1);
    cyc(); chk("t1_addr2", 32'(imem_addr), 32'h2);
    // Three-cycle latency
    cyc(); lat = 3; push(16'h4321, 16'h4, 4'h2, 4'h1);
    chk("t2_addr_c0", 32'(imem_addr), 32'h3);
    cyc(); chk("t2_addr_c1", 32'(imem_addr), 32'h3); chk("t2_bubble1", 32'(if_id_valid), 32'd0);
    cyc(); chk("t2_addr_c2", 32'(imem_addr), 32'h3); chk("t2_bubble2", 32'(if_id_valid), 32'd0);
    // Stall into HOLD
    cyc(); lat = 1; pc_write_en = 1'b0; if_id_write_en = 1'b0; push(16'h5678, 16'h5, 4'h7, 4'h8);
    chk("t3_addr", 32'(imem_addr), 32'h4);
    cyc(); chk("t3_hold_req1", 32'(imem_req), 32'd0); chk("t3_hold_ifid1", 32'(if_id_instr), 32'h4321);
    cyc(); chk("t3_hold_req2", 32'(imem_req), 32'd0); chk("t3_hold_ifid2", 32'(if_id_instr), 32'h4321);
    pc_write_en = 1'b1; if_id_write_en = 1'b1; lat = 3;
    // Redirect with an outstanding request
    cyc(); chk("t4_addr5", 32'(imem_addr), 32'h5); push(16'h1234, 16'h41, 4'h3, 4'h4);
    cyc(); if_id_clean = 1'b1; jump_target = 16'h0040;
    cyc(); if_id_clean = 1'b0;
    chk("t4_redirect_addr", 32'(imem_addr), 32'h40); chk("t4_bubble0", 32'(if_id_valid), 32'd0);
    cyc(); chk("t4_addr_held", 32'(imem_addr), 32'h40); chk("t4_discard", 32'(if_id_valid), 32'd0);
    cyc(); chk("t4_bubble2", 32'(if_id_valid), 32'd0);
    cyc(); chk("t4_bubble3", 32'(if_id_valid), 32'd0);
    // Halt and restart
    cyc(); lat = 1; push(16'hF000, 16'h42, 4'h0, 4'h0);
    chk("t5_addr", 32'(imem_addr), 32'h41);
    cyc(); chk("t5_run0", 32'(run), 32'd0); chk("t5_req0", 32'(imem_req), 32'd0);
    pc_write_en = 1'b0; if_id_write_en = 1'b0;
    cyc(); chk("t5_hlt_held", 32'(if_id_instr), 32'hF000); chk("t5_run0b", 32'(run), 32'd0);
    pc_write_en = 1'b1; if_id_write_en = 1'b1;
    cyc(); chk("t5_halt_bubble", 32'(if_id_valid), 32'd0); chk("t5_req0b", 32'(imem_req), 32'd0);
    if_id_clean = 1'b1; jump_target = 16'h0010;
    push(16'h2AB3, 16'h11, 4'hB, 4'h3);
    push(16'hA5C0, 16'h12, 4'h5, 4'h0);
    cyc(); if_id_clean = 1'b0;
    chk("t5_run1", 32'(run), 32'd1); chk("t5_req1", 32'(imem_req), 32'd1);
    chk("t5_addr10", 32'(imem_addr), 32'h10);
    // LLB field select, then reset while holding
    cyc(); chk("t6_addr11", 32'(imem_addr), 32'h11);
    cyc(); chk("t6_addr12", 32'(imem_addr), 32'h12); pc_write_en = 1'b0; if_id_write_en = 1'b0;
    cyc(); chk("t6_hold_req", 32'(imem_req), 32'd0); rst = 1'b1;
    cyc(); chk_reset("rst2");
    rst = 1'b0; pc_write_en = 1'b1; if_id_write_en = 1'b1;
    push(16'h1123, 16'h1, 4'h2, 4'h3);
    cyc(); chk("t6_addr_after_rst", 32'(imem_addr), 32'h1); rst = 1'b1;
    cyc(); cyc();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
